// File: rtl/mdu_iterative.sv
// Iterative RV64M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Define MDU_DIV_EN to build the divider; otherwise divide ops return 0 on the fast path.
module mdu_iterative #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic            reg_write,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] result
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        f3;
    logic              neg_q;
    logic [XLEN-1:0]   opnd;
    logic [XLEN-1:0]   hi;
    logic [XLEN-1:0]   lo;
    logic [XLEN-1:0]   fin;

    logic              sgn_a;
    logic              sgn_b;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic              fast;
    logic [XLEN-1:0]   fast_val;
    logic [XLEN:0]     sum;
    logic [XLEN-1:0]   nhi;
    logic [XLEN-1:0]   nlo;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   fix_val;

    assign reg_write = done;

    always_comb begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
        unique case (funct3)
            3'b001, 3'b100, 3'b110: begin
                sgn_a = op_a[XLEN-1];
                sgn_b = op_b[XLEN-1];
            end
            3'b010:  sgn_a = op_a[XLEN-1];
            default: ;
        endcase
    end

    assign abs_a = sgn_a ? -op_a : op_a;
    assign abs_b = sgn_b ? -op_b : op_b;

`ifdef MDU_DIV_EN
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic              neg_r;
    logic              b_zero;
    logic              ovf;
    logic [XLEN:0]     sh;
    logic [XLEN:0]     diff;

    assign b_zero = (op_b == '0);
    // Signed overflow only exists for DIV/REM (funct3[0] clear)
    assign ovf    = !funct3[0] && (op_a == MIN_NEG) && (&op_b);

    always_comb begin
        fast     = funct3[2] && (b_zero || ovf);
        fast_val = '0;
        if (b_zero)
            fast_val = funct3[1] ? op_a : '1;
        else
            fast_val = funct3[1] ? '0 : op_a;
    end
`else
    assign fast     = funct3[2];
    assign fast_val = '0;
`endif

    // One iteration: hi:lo is the product (multiply) or remainder:quotient (divide)
    always_comb begin
        sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        nhi = sum[XLEN:1];
        nlo = {sum[0], lo[XLEN-1:1]};
`ifdef MDU_DIV_EN
        sh   = {hi, lo[XLEN-1]};
        diff = sh - {1'b0, opnd};
        if (f3[2]) begin
            if (diff[XLEN]) begin
                nhi = sh[XLEN-1:0];
                nlo = {lo[XLEN-2:0], 1'b0};
            end else begin
                nhi = diff[XLEN-1:0];
                nlo = {lo[XLEN-2:0], 1'b1};
            end
        end
`endif
    end

    always_comb begin
        prod    = neg_q ? -{hi, lo} : {hi, lo};
        fix_val = (f3 == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef MDU_DIV_EN
        if (f3[2])
            fix_val = f3[1] ? (neg_r ? -hi : hi) : (neg_q ? -lo : lo);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            f3     <= '0;
            neg_q  <= 1'b0;
            opnd   <= '0;
            hi     <= '0;
            lo     <= '0;
            fin    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            rd_out <= '0;
            result <= '0;
`ifdef MDU_DIV_EN
            neg_r  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy <= start;
                    if (start) begin
                        f3     <= funct3;
                        rd_out <= rd_in;
                        cnt    <= '0;
                        if (fast) begin
                            fin   <= fast_val;
                            state <= S_DONE;
                        end else begin
                            neg_q <= sgn_a ^ sgn_b;
`ifdef MDU_DIV_EN
                            neg_r <= sgn_a;
`endif
                            opnd  <= funct3[2] ? abs_b : abs_a;
                            lo    <= funct3[2] ? abs_a : abs_b;
                            hi    <= '0;
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    hi  <= nhi;
                    lo  <= nlo;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST)
                        state <= S_FIX;
                end
                S_FIX: begin
                    fin   <= fix_val;
                    state <= S_DONE;
                end
                S_DONE: begin
                    // busy stays high through the done cycle
                    result <= fin;
                    done   <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative (XLEN=64); honours MDU_DIV_EN like the design.
module tb_mdu_iterative;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic        reg_write;
    logic [4:0]  rd_out;
    logic [63:0] result;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mdu_iterative dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .rd_in     (rd_in),
        .busy      (busy),
        .done      (done),
        .reg_write (reg_write),
        .rd_out    (rd_out),
        .result    (result)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input logic [2:0] f,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd, input logic [63:0] exp,
                       input int exp_lat, input int poke);
        int lat;
        @(negedge clk);
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        rd_in  = rd;
        @(posedge clk);
        #1;
        start  = 1'b0;
        op_a   = ~a;
        op_b   = ~b;
        funct3 = ~f;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        lat = 0;
        while (!done && lat < 200) begin
            if (poke > 0 && lat == poke) begin
                start  = 1'b1;
                funct3 = 3'b011;
                op_a   = 64'd3;
                op_b   = 64'd3;
                rd_in  = 5'd9;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_res"}, result, exp);
        check({tag, "_rd"}, 64'(rd_out), 64'(rd));
        check({tag, "_wr"}, 64'(reg_write), 64'd1);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int dones;
        int t;
        logic [2:0] abort_f;
        reset  = 1'b1;
        start  = 1'b0;
        funct3 = 3'b000;
        op_a   = '0;
        op_b   = '0;
        rd_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_wr", 64'(reg_write), 64'd0);
        check("rst_rd", 64'(rd_out), 64'd0);
        check("rst_res", result, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run("mul", 3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5,
            64'hFFFF_FFFF_FFFF_FFEB, 66, 10);
        run("mulhu", 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            5'd1, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0);
        run("mulh", 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            5'd2, 64'd0, 66, 0);
        run("mulhsu", 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
            5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0);

`ifdef MDU_DIV_EN
        run("div", 3'b100, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd4,
            64'hFFFF_FFFF_FFFF_FFFA, 66, 0);
        run("rem", 3'b110, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd6,
            64'hFFFF_FFFF_FFFF_FFFE, 66, 0);
        run("divu", 3'b101, 64'd100, 64'd7, 5'd8, 64'd14, 66, 0);
        run("remu", 3'b111, 64'd100, 64'd7, 5'd10, 64'd2, 66, 0);
        run("divu_z", 3'b101, 64'd9, 64'd0, 5'd11,
            64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
        run("remu_z", 3'b111, 64'd9, 64'd0, 5'd12, 64'd9, 1, 0);
        run("rem_ovf", 3'b110, 64'h8000_0000_0000_0000,
            64'hFFFF_FFFF_FFFF_FFFF, 5'd13, 64'd0, 1, 0);
        run("div_ovf", 3'b100, 64'h8000_0000_0000_0000,
            64'hFFFF_FFFF_FFFF_FFFF, 5'd14, 64'h8000_0000_0000_0000, 1, 0);
        abort_f = 3'b100;
`else
        run("div_off", 3'b100, 64'd100, 64'd7, 5'd4, 64'd0, 1, 0);
        run("remu_off", 3'b111, 64'd100, 64'd7, 5'd6, 64'd0, 1, 0);
        abort_f = 3'b000;
`endif

        // Abort a running operation with reset
        @(negedge clk);
        start  = 1'b1;
        funct3 = abort_f;
        op_a   = 64'hFFFF_FFFF_FFFF_FFEC;
        op_b   = 64'd3;
        rd_in  = 5'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (29) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_res", result, 64'd0);
        check("abort_done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("abort_nodone", 64'(dones), 64'd0);
        run("after_rst", 3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5,
            64'hFFFF_FFFF_FFFF_FFEB, 66, 0);

        // Start held high: spacing between done pulses
        @(negedge clk);
        start  = 1'b1;
        funct3 = 3'b000;
        op_a   = 64'd5;
        op_b   = 64'd6;
        rd_in  = 5'd3;
        t = 0;
        @(posedge clk);
        #1;
        while (!done && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("b2b_first", 64'(t), 64'd66);
        t = 0;
        @(posedge clk);
        #1;
        t = 1;
        while (!done && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        start = 1'b0;
        check("b2b_spacing", 64'(t), 64'd67);
        check("b2b_res", result, 64'd30);
        repeat (3) @(posedge clk);
        #1;
        check("b2b_idle", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Iterative RV64M multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the two source operands (rs1/rs2 read data) and produces a 64-bit result plus a destination tag and write strobe for register-file writeback.
- Shift-add multiply and restoring divide, one bit per cycle; the pipeline stalls on busy.

Parameters:
XLEN, 64, operand/result width; must be even and >= 8.
CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  XLEN  rs1 operand (dividend / multiplicand)
op_b  input  XLEN  rs2 operand (divisor / multiplier)
rd_in  input  5  destination register tag
busy  output  1  high from the cycle after acceptance until done cycle inclusive
done  output  1  one-cycle completion pulse
reg_write  output  1  equals done; drives register-file write enable
rd_out  output  5  latched rd_in, valid while done
result  output  XLEN  result; held until next completion

Behaviour:
- Reset: state IDLE; busy=0, done=0, reg_write=0, rd_out=0, result=0, counter=0. Reset during RUN/FIX aborts the operation with no done pulse.
- States: IDLE -> RUN -> FIX -> DONE -> IDLE; IDLE -> DONE for fast path.
- IDLE: start=1 at edge k latches funct3 and rd_in.
  - Signed ops latch absolute values and record result sign:
    - MULH/DIV/REM: both operands signed.
    - MULHSU: op_a signed only.
    - Result sign: quotient and product = sign_a XOR sign_b; remainder = sign of dividend.
  - Counter cleared; state goes to RUN.
- RUN: XLEN cycles, one partial-product add/shift or one restoring-subtract step per cycle. Counter increments; at counter=XLEN-1 the next state is FIX.
- FIX: apply two's-complement negation per recorded sign, select low half (MUL) or high half (MULH*) of the 2*XLEN product, or quotient/remainder. Register into result.
- DONE: done=reg_write=1 for exactly one cycle, then IDLE.
- Latency: start at edge k -> done high in the cycle following edge k+XLEN+2 (66 cycles edge-to-done for XLEN=64).
- Fast path, decided at acceptance; the next state is DONE, so done is high after edge k+1:
  - DIV/DIVU, op_b=0: result = all ones.
  - REM/REMU, op_b=0: result = op_a.
  - DIV with op_a = most-negative and op_b = -1: result = op_a.
  - REM with op_a = most-negative and op_b = -1: result = 0.
- start while not IDLE: ignored. Operand and funct3 changes after acceptance have no effect.
- start in the DONE cycle: ignored. The earliest back-to-back acceptance is the first IDLE cycle.
- busy is low in IDLE, high in RUN/FIX/DONE.
- No overflow exceptions. All arithmetic is modulo 2^XLEN except the internal 2*XLEN product register.

Optional Feature:
- Macro MDU_DIV_EN.
- Defined: full divide/remainder datapath and divide fast paths as above.
- Undefined: divider logic is not built. funct3[2]=1 takes the fast path with result=0, done after edge k+1. Multiply behaviour is unchanged.

Test Plan:
- MUL, op_a=7, op_b=-3 (0xFFFF_FFFF_FFFF_FFFD) -> result 0xFFFF_FFFF_FFFF_FFEB, done 66 cycles after start, rd_out=rd_in=5, reg_write pulse width 1.
- MULHU, op_a=op_b=0xFFFF_FFFF_FFFF_FFFF -> result 0xFFFF_FFFF_FFFF_FFFE; MULH same operands -> 0x0; MULHSU op_a=-1, op_b=2 -> 0xFFFF_FFFF_FFFF_FFFF.
- DIV op_a=-20, op_b=3 -> -6; REM same -> -2; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU op_b=0, op_a=9 -> result all ones, done at edge k+1; REM most-negative/-1 -> 0 with fast timing; without MDU_DIV_EN, DIV 100/7 -> 0 with fast timing.
- Assert start with new operands while busy at cycle 10 -> ignored, first result unchanged; reset at cycle 30 of a DIV -> busy=0, result=0, no done, next start completes normally.
- Back-to-back: start held high continuously -> second operation accepted in first IDLE cycle after done, spacing 67 cycles between done pulses.
